regfile_ctrl: RTL and testbench
===============================

// Module: regfile_ctrl
// PURPOSE
//  Sequencer and rename-status controller for the 8-entry architectural register file.
//  - Owns the regfile's single write port: after reset, zero-initialises all registers; then commits ROB writes.
//  - Tracks a per-register busy bit and owning ROB tag for the dispatch stage.
//  - Sits between dispatch/ROB commit and the regfile; dispatch uses the busy/tag lookups.
// PARAMETERS
//  DATA_WIDTH  16  register data width
//  REG_IDX_W   3   register index width (NUM_REGS = 2**REG_IDX_W = 8)
//  ROB_TAG_W   3   ROB tag width
// PORTS
//  clk        in   1           clock, all state on rising edge
//  reset_n    in   1           asynchronous, active-low reset
//  dis_valid  in   1           dispatch renames dis_dest to dis_tag this cycle
//  dis_dest   in   REG_IDX_W   dispatch destination register
//  dis_tag    in   ROB_TAG_W   ROB tag allocated to the dispatching instruction
//  dis_sr1    in   REG_IDX_W   source 1 lookup index (also drives rf_sr1)
//  dis_sr2    in   REG_IDX_W   source 2 lookup index (also drives rf_sr2)
//  dis_ready  out  1           1 only in RUN; dispatch is ignored when 0
//  sr1_busy   out  1           busy bit of dis_sr1
//  sr1_tag    out  ROB_TAG_W   owning tag of dis_sr1 (0 when not busy)
//  sr2_busy   out  1           busy bit of dis_sr2
//  sr2_tag    out  ROB_TAG_W   owning tag of dis_sr2 (0 when not busy)
//  cmt_valid  in   1           ROB head commits a register write
//  cmt_dest   in   REG_IDX_W   commit destination
//  cmt_tag    in   ROB_TAG_W   commit ROB tag
//  cmt_data   in   DATA_WIDTH  commit value
//  cmt_ready  out  1           1 only in RUN; commit handshake = cmt_valid & cmt_ready
//  flush      in   1           mispredict/exception recovery: clear all busy bits
//  rf_load    out  1           regfile write enable
//  rf_dest    out  REG_IDX_W   regfile write index
//  rf_in      out  DATA_WIDTH  regfile write data
//  rf_sr1     out  REG_IDX_W   regfile read select A (= dis_sr1)
//  rf_sr2     out  REG_IDX_W   regfile read select B (= dis_sr2)
//  init_done  out  1           registered; 1 once INIT has completed
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-INIT or mid-commit):
//   - state=INIT, init_cnt=0, all busy=0, all tags=0, init_done=0.
//  FSM:
//   - INIT: rf_load=1, rf_dest=init_cnt, rf_in=0; init_cnt increments each cycle.
//     At init_cnt==NUM_REGS-1, go to RUN and set init_done=1 at that edge.
//     Duration is exactly 8 cycles. cmt_ready=0 and dis_ready=0; flush is ignored.
//   - RUN: stays in RUN; only reset leaves RUN.
//  Commit (RUN):
//   - rf_load = cmt_valid, combinationally; rf_dest=cmt_dest, rf_in=cmt_data.
//     The regfile holds the new value after the same edge.
//   - When rf_load=0: rf_dest=cmt_dest, rf_in=cmt_data (don't-care to the regfile).
//   - busy[cmt_dest] clears only if tag[cmt_dest]==cmt_tag (a newer rename keeps ownership).
//  Dispatch (RUN, dis_valid):
//   - busy[dis_dest]<=1, tag[dis_dest]<=dis_tag; visible on lookups the next cycle.
//  Simultaneous events:
//   - Dispatch and commit to the same register: dispatch wins (busy=1, tag=dis_tag); the regfile write still occurs.
//   - Flush with commit: the regfile write occurs; all busy/tags clear.
//   - Flush with dispatch: the dispatch update is dropped.
//  Lookups:
//   - Combinational from registered table state; no bypass of same-cycle dispatch/commit.
//   - Tag output is 0 whenever busy=0.
//  Widths: dis_dest/cmt_dest index the table directly; every index is legal (no wrap or check needed).
// STRUCTURE
//  lc3b_types additions:
//   - typedef logic [REG_IDX_W-1:0] lc3b_reg_idx
//   - typedef logic [ROB_TAG_W-1:0] lc3b_rob_tag
//   - enum {RC_INIT, RC_RUN} regctl_state_t
//   - localparam NUM_REGS
//  Sub-module regstat_table holds the busy/tag array: 2 lookup ports, 1 rename port, 1 conditional-clear port, flush.
//  regfile_ctrl holds the FSM, init counter and write-port mux.
// TESTING
//  1. Reset release -> rf_load=1 for 8 cycles with rf_dest 0..7, rf_in=0; then init_done=1, cmt_ready=1.
//  2. Assert cmt_valid during INIT -> cmt_ready=0 and no commit write; dis_valid ignored (R2 not busy after INIT).
//  3. Dispatch R3 tag5; next cycle lookup R3 -> busy=1, tag=5; commit R3 tag5 data 0xBEEF -> regfile R3=0xBEEF, busy=0.
//  4. Dispatch R1 tag2, then dispatch R1 tag6, then commit R1 tag2 -> busy stays 1 with tag=6.
//  5. Same cycle: dispatch R4 tag7 + commit R4 tag4 (owner 4) -> R4 written, busy=1, tag=7.
//  6. Flush with dispatch R0 tag1 pending -> all busy=0. Reset_n pulse at INIT cycle 3 -> INIT restarts at rf_dest=0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizing for the register-file controller.
// Widths here size every port of the controller and its status table.
package regfile_ctrl_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int REG_IDX_W  = 3;
    localparam int ROB_TAG_W  = 3;
    localparam int NUM_REGS   = 2 ** REG_IDX_W;

    typedef logic [REG_IDX_W-1:0]  lc3b_reg_idx;
    typedef logic [ROB_TAG_W-1:0]  lc3b_rob_tag;
    typedef logic [DATA_WIDTH-1:0] lc3b_word;

    typedef enum logic {RC_INIT, RC_RUN} regctl_state_t;
endpackage

// File: rtl/regfile_ctrl_if.sv
// Dispatch, commit and regfile-port bundle for regfile_ctrl.
// master = dispatch/ROB/regfile side, slave = the controller.
interface regfile_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic        dis_valid;
    lc3b_reg_idx dis_dest;
    lc3b_rob_tag dis_tag;
    lc3b_reg_idx dis_sr1;
    lc3b_reg_idx dis_sr2;
    logic        dis_ready;
    logic        sr1_busy;
    lc3b_rob_tag sr1_tag;
    logic        sr2_busy;
    lc3b_rob_tag sr2_tag;
    logic        cmt_valid;
    lc3b_reg_idx cmt_dest;
    lc3b_rob_tag cmt_tag;
    lc3b_word    cmt_data;
    logic        cmt_ready;
    logic        flush;
    logic        rf_load;
    lc3b_reg_idx rf_dest;
    lc3b_word    rf_in;
    lc3b_reg_idx rf_sr1;
    lc3b_reg_idx rf_sr2;
    logic        init_done;

    modport master (
        output dis_valid, dis_dest, dis_tag, dis_sr1, dis_sr2,
        output cmt_valid, cmt_dest, cmt_tag, cmt_data, flush,
        input  dis_ready, sr1_busy, sr1_tag, sr2_busy, sr2_tag,
        input  cmt_ready, rf_load, rf_dest, rf_in, rf_sr1, rf_sr2,
        input  init_done
    );

    modport slave (
        input  dis_valid, dis_dest, dis_tag, dis_sr1, dis_sr2,
        input  cmt_valid, cmt_dest, cmt_tag, cmt_data, flush,
        output dis_ready, sr1_busy, sr1_tag, sr2_busy, sr2_tag,
        output cmt_ready, rf_load, rf_dest, rf_in, rf_sr1, rf_sr2,
        output init_done
    );
endinterface

// File: rtl/regfile_ctrl_regstat_table.sv
// Per-register busy bit and owning ROB tag, with rename,
// tag-matched commit clear and flush.
module regstat_table
    import regfile_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic        ren_i,
    input  lc3b_reg_idx ren_idx_i,
    input  lc3b_rob_tag ren_tag_i,
    input  logic        clr_i,
    input  lc3b_reg_idx clr_idx_i,
    input  lc3b_rob_tag clr_tag_i,
    input  lc3b_reg_idx sr1_i,
    input  lc3b_reg_idx sr2_i,
    output logic        sr1_busy_o,
    output lc3b_rob_tag sr1_tag_o,
    output logic        sr2_busy_o,
    output lc3b_rob_tag sr2_tag_o
);
    logic [NUM_REGS-1:0]                busy_q, busy_d;
    logic [NUM_REGS-1:0][ROB_TAG_W-1:0] tag_q, tag_d;

    // Priority: flush, then rename, then a commit whose tag still owns the entry.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end else if (ren_i && ren_idx_i == REG_IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = ren_tag_i;
            end else if (clr_i && clr_idx_i == REG_IDX_W'(i)
                         && tag_q[i] == clr_tag_i) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    assign sr1_busy_o = busy_q[sr1_i];
    assign sr1_tag_o  = busy_q[sr1_i] ? tag_q[sr1_i] : '0;
    assign sr2_busy_o = busy_q[sr2_i];
    assign sr2_tag_o  = busy_q[sr2_i] ? tag_q[sr2_i] : '0;
endmodule

// File: rtl/regfile_ctrl.sv
// Regfile write-port sequencer: zero-fills all registers after reset,
// then commits ROB writes and tracks rename status for dispatch.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    regfile_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_INIT = 1'(RC_INIT);
    localparam logic [0:0] ST_RUN  = 1'(RC_RUN);

    logic [0:0]  state_q, state_d;
    lc3b_reg_idx init_cnt_q, init_cnt_d;
    logic        init_done_q, init_done_d;
    logic        run;

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        unique case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == REG_IDX_W'(NUM_REGS - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.dis_ready = run;
    assign bus.cmt_ready = run;
    assign bus.init_done = init_done_q;
    assign bus.rf_load   = run ? bus.cmt_valid : 1'b1;
    assign bus.rf_dest   = run ? bus.cmt_dest : init_cnt_q;
    assign bus.rf_in     = run ? bus.cmt_data : '0;
    assign bus.rf_sr1    = bus.dis_sr1;
    assign bus.rf_sr2    = bus.dis_sr2;

    regstat_table u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_i    (run & bus.flush),
        .ren_i      (run & bus.dis_valid),
        .ren_idx_i  (bus.dis_dest),
        .ren_tag_i  (bus.dis_tag),
        .clr_i      (run & bus.cmt_valid),
        .clr_idx_i  (bus.cmt_dest),
        .clr_tag_i  (bus.cmt_tag),
        .sr1_i      (bus.dis_sr1),
        .sr2_i      (bus.dis_sr2),
        .sr1_busy_o (bus.sr1_busy),
        .sr1_tag_o  (bus.sr1_tag),
        .sr2_busy_o (bus.sr2_busy),
        .sr2_tag_o  (bus.sr2_tag)
    );
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: init sequence, rename/commit
// ownership, same-cycle interactions, flush and mid-INIT reset.
module tb_regfile_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] rf_mem [8];

    regfile_ctrl_if bus ();

    regfile_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // External regfile as it would see the write port.
    always @(posedge clk)
        if (bus.rf_load) rf_mem[bus.rf_dest] <= bus.rf_in;

    task automatic idle_inputs();
        bus.dis_valid = 0; bus.dis_dest = 0; bus.dis_tag = 0;
        bus.dis_sr1 = 0; bus.dis_sr2 = 0;
        bus.cmt_valid = 0; bus.cmt_dest = 0; bus.cmt_tag = 0;
        bus.cmt_data = 0; bus.flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        @(negedge clk); #1;
        tests++;
        if ({bus.init_done, bus.cmt_ready, bus.dis_ready, bus.rf_load,
             bus.rf_dest, bus.rf_in} !== {3'b000, 1'b1, 3'd0, 16'h0}) begin
            fails++;
            $display("FAIL reset_state got id=%b cr=%b dr=%b ld=%b d=%0d in=%h",
                     bus.init_done, bus.cmt_ready, bus.dis_ready,
                     bus.rf_load, bus.rf_dest, bus.rf_in);
        end
        tests++;
        if ({bus.sr1_busy, bus.sr1_tag, bus.sr2_busy, bus.sr2_tag} !== 8'h0) begin
            fails++;
            $display("FAIL reset_lookup got b1=%b t1=%0d b2=%b t2=%0d exp 0",
                     bus.sr1_busy, bus.sr1_tag, bus.sr2_busy, bus.sr2_tag);
        end
    endtask

    task automatic test_init_seq();
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests++;
            if ({bus.rf_load, bus.rf_dest, bus.rf_in, bus.cmt_ready,
                 bus.dis_ready, bus.init_done} !== {1'b1, 3'(i), 16'h0, 3'b000}) begin
                fails++;
                $display("FAIL init_cycle%0d got ld=%b d=%0d in=%h cr=%b id=%b exp ld=1 d=%0d in=0",
                         i, bus.rf_load, bus.rf_dest, bus.rf_in,
                         bus.cmt_ready, bus.init_done, i);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if ({bus.init_done, bus.cmt_ready, bus.dis_ready, bus.rf_load} !== 4'b1110) begin
            fails++;
            $display("FAIL init_end got id=%b cr=%b dr=%b ld=%b exp 1110",
                     bus.init_done, bus.cmt_ready, bus.dis_ready, bus.rf_load);
        end
    endtask

    task automatic test_init_ignore();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        bus.cmt_valid = 1; bus.cmt_dest = 5; bus.cmt_tag = 5;
        bus.cmt_data = 16'h1234;
        bus.dis_valid = 1; bus.dis_dest = 2; bus.dis_tag = 3;
        bus.dis_sr1 = 2;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests++;
            if ({bus.cmt_ready, bus.rf_load, bus.rf_dest, bus.rf_in} !==
                {1'b0, 1'b1, 3'(i), 16'h0}) begin
                fails++;
                $display("FAIL init_ignore%0d got cr=%b d=%0d in=%h exp cr=0 d=%0d in=0",
                         i, bus.cmt_ready, bus.rf_dest, bus.rf_in, i);
            end
            @(negedge clk);
        end
        idle_inputs();
        bus.dis_sr1 = 2;
        #1;
        tests++;
        if ({bus.sr1_busy, bus.init_done} !== 2'b01) begin
            fails++;
            $display("FAIL init_dispatch_dropped got busy=%b id=%b exp busy=0 id=1",
                     bus.sr1_busy, bus.init_done);
        end
    endtask

    task automatic test_dispatch_commit();
        @(negedge clk);
        bus.dis_valid = 1; bus.dis_dest = 3; bus.dis_tag = 5; bus.dis_sr1 = 3;
        #1;
        tests++;
        if (bus.sr1_busy !== 1'b0) begin
            fails++;
            $display("FAIL no_bypass got busy=%b exp 0", bus.sr1_busy);
        end
        @(negedge clk);
        bus.dis_valid = 0;
        #1;
        tests++;
        if ({bus.sr1_busy, bus.sr1_tag, bus.rf_sr1} !== {1'b1, 3'd5, 3'd3}) begin
            fails++;
            $display("FAIL r3_busy got busy=%b tag=%0d sel=%0d exp 1/5/3",
                     bus.sr1_busy, bus.sr1_tag, bus.rf_sr1);
        end
        bus.cmt_valid = 1; bus.cmt_dest = 3; bus.cmt_tag = 5;
        bus.cmt_data = 16'hBEEF;
        #1;
        tests++;
        if ({bus.rf_load, bus.rf_dest, bus.rf_in} !== {1'b1, 3'd3, 16'hBEEF}) begin
            fails++;
            $display("FAIL commit_port got ld=%b d=%0d in=%h exp 1/3/beef",
                     bus.rf_load, bus.rf_dest, bus.rf_in);
        end
        @(negedge clk);
        bus.cmt_valid = 0;
        #1;
        tests++;
        if ({bus.sr1_busy, bus.sr1_tag, bus.rf_load, rf_mem[3]} !==
            {1'b0, 3'd0, 1'b0, 16'hBEEF}) begin
            fails++;
            $display("FAIL r3_commit got busy=%b tag=%0d ld=%b rf=%h exp 0/0/0/beef",
                     bus.sr1_busy, bus.sr1_tag, bus.rf_load, rf_mem[3]);
        end
    endtask

    task automatic test_rename_owner();
        @(negedge clk);
        bus.dis_valid = 1; bus.dis_dest = 1; bus.dis_tag = 2;
        @(negedge clk);
        bus.dis_tag = 6;
        @(negedge clk);
        bus.dis_valid = 0;
        bus.cmt_valid = 1; bus.cmt_dest = 1; bus.cmt_tag = 2;
        bus.cmt_data = 16'h0A0A;
        @(negedge clk);
        bus.cmt_valid = 0; bus.dis_sr2 = 1;
        #1;
        tests++;
        if ({bus.sr2_busy, bus.sr2_tag, rf_mem[1]} !== {1'b1, 3'd6, 16'h0A0A}) begin
            fails++;
            $display("FAIL stale_commit got busy=%b tag=%0d rf=%h exp 1/6/0a0a",
                     bus.sr2_busy, bus.sr2_tag, rf_mem[1]);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.dis_valid = 1; bus.dis_dest = 4; bus.dis_tag = 4;
        @(negedge clk);
        bus.dis_tag = 7;
        bus.cmt_valid = 1; bus.cmt_dest = 4; bus.cmt_tag = 4;
        bus.cmt_data = 16'h4444;
        @(negedge clk);
        bus.dis_valid = 0; bus.cmt_valid = 0; bus.dis_sr1 = 4;
        #1;
        tests++;
        if ({bus.sr1_busy, bus.sr1_tag, rf_mem[4]} !== {1'b1, 3'd7, 16'h4444}) begin
            fails++;
            $display("FAIL dispatch_wins got busy=%b tag=%0d rf=%h exp 1/7/4444",
                     bus.sr1_busy, bus.sr1_tag, rf_mem[4]);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.flush = 1;
        bus.dis_valid = 1; bus.dis_dest = 0; bus.dis_tag = 1;
        bus.cmt_valid = 1; bus.cmt_dest = 5; bus.cmt_tag = 0;
        bus.cmt_data = 16'h5555;
        #1;
        tests++;
        if ({bus.rf_load, bus.rf_dest} !== {1'b1, 3'd5}) begin
            fails++;
            $display("FAIL flush_commit_port got ld=%b d=%0d exp 1/5",
                     bus.rf_load, bus.rf_dest);
        end
        @(negedge clk);
        idle_inputs();
        bus.dis_sr1 = 0; bus.dis_sr2 = 1;
        #1;
        tests++;
        if ({bus.sr1_busy, bus.sr1_tag, bus.sr2_busy, bus.sr2_tag, rf_mem[5]} !==
            {8'h0, 16'h5555}) begin
            fails++;
            $display("FAIL flush_r0_r1 got b0=%b t0=%0d b1=%b t1=%0d rf5=%h exp 0s/5555",
                     bus.sr1_busy, bus.sr1_tag, bus.sr2_busy, bus.sr2_tag, rf_mem[5]);
        end
        bus.dis_sr2 = 4;
        #1;
        tests++;
        if ({bus.sr2_busy, bus.sr2_tag} !== 4'h0) begin
            fails++;
            $display("FAIL flush_r4 got busy=%b tag=%0d exp 0/0",
                     bus.sr2_busy, bus.sr2_tag);
        end
    endtask

    task automatic test_reset_mid_init();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (bus.rf_dest !== 3'd3) begin
            fails++;
            $display("FAIL mid_init_cnt got d=%0d exp 3", bus.rf_dest);
        end
        reset_n = 0;
        #1;
        tests++;
        if ({bus.rf_load, bus.rf_dest, bus.init_done} !== {1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset got ld=%b d=%0d id=%b exp 1/0/0",
                     bus.rf_load, bus.rf_dest, bus.init_done);
        end
        reset_n = 1;
        @(negedge clk); #1;
        tests++;
        if (bus.rf_dest !== 3'd1) begin
            fails++;
            $display("FAIL restart_cnt got d=%0d exp 1", bus.rf_dest);
        end
        repeat (6) @(negedge clk);
        #1;
        tests++;
        if ({bus.rf_dest, bus.init_done, bus.cmt_ready} !== {3'd7, 2'b00}) begin
            fails++;
            $display("FAIL restart_last got d=%0d id=%b cr=%b exp 7/0/0",
                     bus.rf_dest, bus.init_done, bus.cmt_ready);
        end
        @(negedge clk); #1;
        tests++;
        if ({bus.init_done, bus.cmt_ready} !== 2'b11) begin
            fails++;
            $display("FAIL restart_done got id=%b cr=%b exp 1/1",
                     bus.init_done, bus.cmt_ready);
        end
    endtask

    initial begin
        test_reset();
        test_init_seq();
        test_init_ignore();
        test_dispatch_commit();
        test_rename_owner();
        test_same_cycle();
        test_flush();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
